// File: rtl/int_request_arbiter.sv
// Interrupt request arbiter: synchronises external lines, tracks edge/level pending
// state, and issues one fixed-priority request at a time to the interrupt controller.
module int_request_arbiter #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 3
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_SRC-1:0] ext_int,
  input  logic [NUM_SRC-1:0] int_mask,
  input  logic [NUM_SRC-1:0] int_trigger,
  input  logic               isr_active,
  input  logic               isr_done,
  output logic               interrupt_signal,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Lowest set index wins; scanning downward lets the lowest index overwrite last.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = vec[i] ? ID_W'(i) : idx;
    end
    return idx;
  endfunction

  logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];
  logic [NUM_SRC-1:0] s_int_s;
  logic [NUM_SRC-1:0] s_int_d_r;
  logic               act_d_r;
  state_t             state_r;

  logic [NUM_SRC-1:0] rise_s;
  logic               ack_s;
  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] pending_nxt_s;
  state_t             state_nxt_s;
  logic               irq_nxt_s;
  logic [ID_W-1:0]    id_nxt_s;
  logic               busy_nxt_s;

  assign s_int_s = sync_r[SYNC_STAGES-1];

  // Per-line multi-flop synchroniser.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= {NUM_SRC{1'b0}};
      end
    end else begin
      sync_r[0] <= ext_int;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // History flops for edge detection on the synced lines and on isr_active.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_int_d_r <= {NUM_SRC{1'b0}};
      act_d_r   <= 1'b0;
    end else begin
      s_int_d_r <= s_int_s;
      act_d_r   <= isr_active;
    end
  end

  // Pending-flag next state: edge bits set-dominant over ack clear, level bits track the line.
  always_comb begin
    rise_s        = s_int_s & ~s_int_d_r;
    ack_s         = isr_active & ~act_d_r;
    req_s         = pending & int_mask;
    clr_s         = {NUM_SRC{1'b0}};
    pending_nxt_s = {NUM_SRC{1'b0}};
    if ((state_r == REQ) && ack_s) begin
      clr_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << int_id;
    end else begin
      clr_s = {NUM_SRC{1'b0}};
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int_trigger[i]) begin
        pending_nxt_s[i] = rise_s[i] | (pending[i] & ~clr_s[i]);
      end else begin
        pending_nxt_s[i] = s_int_s[i];
      end
    end
  end

  // Handshake FSM next state and registered-output next values.
  always_comb begin
    state_nxt_s = state_r;
    irq_nxt_s   = interrupt_signal;
    id_nxt_s    = int_id;
    busy_nxt_s  = busy;
    case (state_r)
      IDLE: begin
        if (|req_s) begin
          id_nxt_s    = lowest_idx(req_s);
          irq_nxt_s   = 1'b1;
          busy_nxt_s  = 1'b1;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        // isr_done is deliberately ignored here; only the ack edge moves us on.
        if (ack_s) begin
          irq_nxt_s   = 1'b0;
          state_nxt_s = SERVICE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      SERVICE: begin
        if (isr_done) begin
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVICE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        irq_nxt_s   = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r          <= IDLE;
      interrupt_signal <= 1'b0;
      int_id           <= {ID_W{1'b0}};
      busy             <= 1'b0;
      pending          <= {NUM_SRC{1'b0}};
    end else begin
      state_r          <= state_nxt_s;
      interrupt_signal <= irq_nxt_s;
      int_id           <= id_nxt_s;
      busy             <= busy_nxt_s;
      pending          <= pending_nxt_s;
    end
  end

endmodule
